// File: rtl/proc_seq_pkg.sv
// Shared definitions for the program sequencer: FSM state encoding and the
// layout of a program memory entry ({operand_flag, word}).
package proc_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_ISSUE,
    S_WAIT,
    S_ADV,
    S_HALT,
    S_ERROR
  } state_e;

  localparam int PROC_N   = 8;
  localparam int OPND_BIT = PROC_N;

  // Operand flag sits just above the instruction word for any width n.
  function automatic int opnd_bit(input int n);
    return n;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Step push-button conditioning: 2-flop synchronizer, stable-sample counter
// and a single-cycle pulse on the debounced rising edge.
module key_debounce #(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic step_pulse
);

  localparam int CW = $clog2(DB_CYCLES + 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          level_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      level_q    <= 1'b0;
      cnt_q      <= '0;
      step_pulse <= 1'b0;
    end else begin
      sync1_q    <= key;
      sync2_q    <= sync1_q;
      step_pulse <= 1'b0;
      // Any sample matching the current level restarts the stability run.
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DB_CYCLES - 1)) begin
        cnt_q      <= '0;
        level_q    <= sync2_q;
        step_pulse <= sync2_q;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/proc_sequencer.sv
// Drives the processor Run/DIN handshake from a loadable program memory,
// free-running or stepping one instruction per debounced key press.
module proc_sequencer
  import proc_seq_pkg::*;
#(
  parameter  int N         = PROC_N,
  parameter  int DEPTH     = 16,
  parameter  int DB_CYCLES = 4,
  parameter  int TIMEOUT   = 255,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          key,
  input  logic          mode,
  input  logic          start,
  input  logic          abort,
  input  logic          load_we,
  input  logic [AW-1:0] load_addr,
  input  logic [N:0]    load_data,
  input  logic [AW:0]   prog_len,
  input  logic          proc_done,
  output logic [N-1:0]  proc_din,
  output logic          proc_run,
  output logic [AW:0]   pc,
  output logic          busy,
  output logic          halted,
  output logic          err_timeout
);

  localparam int          TW      = $clog2(TIMEOUT + 1);
  localparam int          FLAG    = opnd_bit(N);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [N:0]    mem_q [DEPTH];
  state_e        st_q, st_d;
  logic [AW:0]   pc_q, pc_d, pc_adv;
  logic [TW-1:0] timer_q, timer_d;
  logic          err_q, err_d;
  logic [N-1:0]  din_q;
  logic [AW:0]   len_c;
  logic [AW-1:0] pc_idx, nxt_idx;
  logic [N-1:0]  cur_word;
  logic [N:0]    nxt_ent;
  logic          idle_like;
  logic          step_pulse;

  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_key (
    .clk       (clk),
    .rst       (rst),
    .key       (key),
    .step_pulse(step_pulse)
  );

  assign len_c     = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
  assign pc_idx    = pc_q[AW-1:0];
  assign nxt_idx   = pc_idx + AW'(1);
  assign cur_word  = mem_q[pc_idx][N-1:0];
  assign nxt_ent   = mem_q[nxt_idx];
  assign pc_adv    = pc_q + (AW+1)'(1) + (AW+1)'(nxt_ent[FLAG]);
  assign idle_like = (st_q == S_IDLE) || (st_q == S_HALT) || (st_q == S_ERROR);

  // Program memory is deliberately not reset; it survives rst.
  always_ff @(posedge clk) begin
    if (load_we && idle_like) mem_q[load_addr] <= load_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q    <= S_IDLE;
      pc_q    <= '0;
      timer_q <= '0;
      err_q   <= 1'b0;
      din_q   <= '0;
    end else begin
      st_q    <= st_d;
      pc_q    <= pc_d;
      timer_q <= timer_d;
      err_q   <= err_d;
      din_q   <= proc_din;
    end
  end

  always_comb begin
    st_d    = st_q;
    pc_d    = pc_q;
    timer_d = timer_q;
    err_d   = err_q;
    case (st_q)
      S_IDLE, S_HALT, S_ERROR: begin
        if (start) begin
          pc_d  = '0;
          err_d = 1'b0;
          if (len_c == '0) st_d = S_HALT;
          else             st_d = mode ? S_ISSUE : S_ARM;
        end
      end
      S_ARM: begin
        if (step_pulse) st_d = S_ISSUE;
      end
      S_ISSUE: begin
        timer_d = '0;
        st_d    = S_WAIT;
      end
      S_WAIT: begin
        timer_d = timer_q + TW'(1);
        // Done has priority over a timeout in the same cycle.
        if (proc_done) begin
          st_d = S_ADV;
        end else if (timer_q == TW'(TIMEOUT)) begin
          st_d  = S_ERROR;
          err_d = 1'b1;
        end
      end
      S_ADV: begin
        pc_d = pc_adv;
        if (pc_adv >= len_c) st_d = S_HALT;
        else                 st_d = mode ? S_ISSUE : S_ARM;
      end
      default: st_d = S_IDLE;
    endcase
    if (abort) begin
      st_d    = S_IDLE;
      pc_d    = pc_q;
      err_d   = err_q;
      timer_d = timer_q;
    end
  end

  // WAIT shows the following entry so an operand word is ready for the processor.
  always_comb begin
    case (st_q)
      S_ISSUE: proc_din = cur_word;
      S_WAIT:  proc_din = nxt_ent[N-1:0];
      default: proc_din = din_q;
    endcase
  end

  assign proc_run    = (st_q == S_ISSUE);
  assign busy        = (st_q == S_ISSUE) || (st_q == S_WAIT) ||
                       (st_q == S_ADV)   || (st_q == S_ARM);
  assign halted      = (st_q == S_HALT);
  assign pc          = pc_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_proc_sequencer.sv
// Directed bench for proc_sequencer: cycle table for a free-run program plus
// hand sequences for stepping, timeout, abort, length clamp and reset.
`timescale 1ns/1ps
module tb_proc_sequencer;

  localparam int N         = 8;
  localparam int DEPTH     = 16;
  localparam int AW        = 4;
  localparam int DB_CYCLES = 4;
  localparam int TIMEOUT   = 255;

  logic          clk = 1'b0;
  logic          rst;
  logic          key;
  logic          mode;
  logic          start;
  logic          abort;
  logic          load_we;
  logic [AW-1:0] load_addr;
  logic [N:0]    load_data;
  logic [AW:0]   prog_len;
  logic          proc_done;
  logic [N-1:0]  proc_din;
  logic          proc_run;
  logic [AW:0]   pc;
  logic          busy;
  logic          halted;
  logic          err_timeout;

  logic resp_done = 1'b0;
  logic man_done  = 1'b0;
  int   done_delay = 0;
  int   done_arm   = 0;
  int   checks     = 0;
  int   failures   = 0;

  assign proc_done = resp_done | man_done;

  proc_sequencer #(.N(N), .DEPTH(DEPTH), .DB_CYCLES(DB_CYCLES), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .key(key), .mode(mode), .start(start), .abort(abort),
    .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
    .prog_len(prog_len), .proc_done(proc_done), .proc_din(proc_din),
    .proc_run(proc_run), .pc(pc), .busy(busy), .halted(halted),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // Processor model: raises Done for one cycle done_delay cycles after Run.
  initial begin
    forever begin
      @(negedge clk);
      resp_done = 1'b0;
      if (done_arm > 0) begin
        done_arm--;
        if (done_arm == 0) resp_done = 1'b1;
      end
      if (proc_run && done_delay > 0) done_arm = done_delay;
    end
  end

  typedef struct packed {
    logic       start;
    logic       done;
    logic       run;
    logic [7:0] din;
    logic [4:0] pc;
    logic       busy;
    logic       halted;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load(input int a, input logic [N:0] d);
    @(negedge clk);
    load_we   = 1'b1;
    load_addr = a[AW-1:0];
    load_data = d;
    @(negedge clk);
    load_we   = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_run(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!proc_run && n < 40);
    chk(name, proc_run, 1'b1);
  endtask

  task automatic run_to_halt(input string name, output int runs, output logic [N-1:0] first);
    int n;
    runs  = 0;
    first = '0;
    n     = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
      if (proc_run) begin
        if (runs == 0) first = proc_din;
        runs++;
      end
    end while (!halted && n < 300);
    chk(name, halted, 1'b1);
  endtask

  task automatic press(output int runs, output logic [N-1:0] first);
    runs  = 0;
    first = '0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (i < 50) key = (i == 1) ? 1'b0 : 1'b1;
      else        key = (i == 51) ? 1'b1 : 1'b0;
      #1;
      if (proc_run) begin
        if (runs == 0) first = proc_din;
        runs++;
      end
    end
  endtask

  initial begin
    int            runs;
    int            n;
    logic [N-1:0]  first;

    rst = 1'b0; key = 1'b0; mode = 1'b1; start = 1'b0; abort = 1'b0;
    load_we = 1'b0; load_addr = '0; load_data = '0; prog_len = 5'd3;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_run", proc_run, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_err", err_timeout, 1'b0);
    chk("rst_pc", pc, 5'd0);
    chk("rst_din", proc_din, 8'h00);
    rst = 1'b1;

    load(0, {1'b0, 8'h40});
    load(1, {1'b1, 8'h05});
    load(2, {1'b0, 8'h10});
    load(3, {1'b0, 8'h77});

    // start, done, run, din, pc, busy, halted
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 8'h40, 5'd0, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 8'h05, 5'd0, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 8'h05, 5'd0, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 8'h05, 5'd0, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 8'h10, 5'd2, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 8'h77, 5'd2, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 8'h77, 5'd2, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 8'h77, 5'd2, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 8'h77, 5'd3, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 8'h77, 5'd3, 1'b0, 1'b1};

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      start    = tbl[i].start;
      man_done = tbl[i].done;
      #1;
      chk($sformatf("tbl%0d_run", i), proc_run, tbl[i].run);
      chk($sformatf("tbl%0d_din", i), proc_din, tbl[i].din);
      chk($sformatf("tbl%0d_pc", i), pc, tbl[i].pc);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].busy);
      chk($sformatf("tbl%0d_halted", i), halted, tbl[i].halted);
    end
    start    = 1'b0;
    man_done = 1'b0;

    // Single-step with bouncing key
    mode = 1'b0;
    done_delay = 1;
    pulse_start();
    @(negedge clk);
    #1;
    chk("arm_busy", busy, 1'b1);
    chk("arm_pc", pc, 5'd0);
    runs = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      if (proc_run) runs++;
    end
    chk("arm_no_run", runs, 0);
    press(runs, first);
    chk("step1_runs", runs, 1);
    chk("step1_din", first, 8'h40);
    chk("step1_pc", pc, 5'd2);
    chk("step1_busy", busy, 1'b1);
    press(runs, first);
    chk("step2_runs", runs, 1);
    chk("step2_din", first, 8'h10);
    chk("step2_pc", pc, 5'd3);
    chk("step2_halted", halted, 1'b1);

    // Done never arrives
    mode = 1'b1;
    done_delay = 0;
    pulse_start();
    wait_run("to_run");
    n = 0;
    while (!err_timeout && n < 400) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("to_cycles", n, TIMEOUT + 2);
    chk("to_run_low", proc_run, 1'b0);
    chk("to_busy", busy, 1'b0);
    chk("to_din_hold", proc_din, 8'h05);
    done_delay = 2;
    pulse_start();
    @(negedge clk);
    #1;
    chk("to_restart_err", err_timeout, 1'b0);
    chk("to_restart_run", proc_run, 1'b1);
    chk("to_restart_pc", pc, 5'd0);
    chk("to_restart_din", proc_din, 8'h40);
    run_to_halt("to_rerun_halt", runs, first);
    chk("to_rerun_pc", pc, 5'd3);

    // Abort during the second WAIT, then start+abort together
    done_delay = 1;
    pulse_start();
    wait_run("ab_run1");
    done_delay = 0;
    wait_run("ab_run2");
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    #1;
    chk("ab_busy", busy, 1'b0);
    chk("ab_run", proc_run, 1'b0);
    chk("ab_halted", halted, 1'b0);
    chk("ab_pc", pc, 5'd2);
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    #1;
    chk("ab_both_busy", busy, 1'b0);
    chk("ab_both_halted", halted, 1'b0);

    // Reset in the middle of WAIT
    done_delay = 1;
    pulse_start();
    wait_run("rs_run1");
    done_delay = 0;
    wait_run("rs_run2");
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rs_run", proc_run, 1'b0);
    chk("rs_busy", busy, 1'b0);
    chk("rs_pc", pc, 5'd0);
    chk("rs_din", proc_din, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    done_delay = 2;
    pulse_start();
    run_to_halt("rs_rerun_halt", runs, first);
    chk("rs_rerun_runs", runs, 2);
    chk("rs_rerun_din", first, 8'h40);
    chk("rs_rerun_pc", pc, 5'd3);

    // Empty program
    prog_len = 5'd0;
    pulse_start();
    @(negedge clk);
    #1;
    chk("len0_halted", halted, 1'b1);
    chk("len0_run", proc_run, 1'b0);
    chk("len0_pc", pc, 5'd0);

    // Oversized length clamps to DEPTH; writes while busy are dropped
    for (int i = 0; i < DEPTH; i++) load(i, {1'b0, 8'(8'h20 + i)});
    prog_len = 5'd20;
    done_delay = 1;
    pulse_start();
    @(negedge clk);
    #1;
    chk("clamp_first_din", proc_din, 8'h20);
    load_we   = 1'b1;
    load_addr = '0;
    load_data = {1'b0, 8'hEE};
    @(negedge clk);
    load_we = 1'b0;
    run_to_halt("clamp_halt", runs, first);
    chk("clamp_runs", runs, 15);
    chk("clamp_pc", pc, 5'd16);
    prog_len = 5'd1;
    pulse_start();
    @(negedge clk);
    #1;
    chk("busy_write_ignored", proc_din, 8'h20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
